// File: rtl/logic_op_pkg.sv
// Shared definitions for the logic-unit command issuer: opcode values,
// issue FSM state encoding, default operand width and the golden model
// used to self-check results coming back from the logic unit.
package logic_op_pkg;

  localparam int unsigned DEF_DATA_W = 4;

  localparam logic [1:0] OP_AND = 2'd0;
  localparam logic [1:0] OP_OR  = 2'd1;
  localparam logic [1:0] OP_XOR = 2'd2;
  localparam logic [1:0] OP_NOT = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2
  } state_t;

  // Expected logic unit output; b is ignored for OP_NOT.
  function automatic logic [DEF_DATA_W-1:0] logic_ref(
    input logic [DEF_DATA_W-1:0] a,
    input logic [DEF_DATA_W-1:0] b,
    input logic [1:0]            f
  );
    case (f)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return ~a;
    endcase
  endfunction

endpackage

// File: rtl/logic_cmd_fifo.sv
// Command FIFO: DEPTH entries of W bits, head visible combinationally.
// Ports: push/wr_data write when not full; pop advances the head when not
//        empty; rd_data is the current head; count/full/empty report
//        occupancy. Asynchronous active-high reset empties the FIFO.
module logic_cmd_fifo #(
  parameter int unsigned W     = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wr_data,
  input  logic                     pop,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/logic_op_issuer.sv
// Command-side driver for the registered logic unit. Buffers commands in a
// FIFO, issues one at a time on unit_a/unit_b/unit_f, captures unit_out two
// edges later, checks it against the golden model and offers it on the
// result port.
// Ports: cmd_* valid/ready command input; unit_* drive the logic unit and
//        unit_out is its registered output; res_* valid/ready result output
//        with the producing opcode; err is a sticky mismatch flag; count is
//        FIFO occupancy.
module logic_op_issuer
  import logic_op_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [DATA_W-1:0]      cmd_a,
  input  logic [DATA_W-1:0]      cmd_b,
  input  logic [1:0]             cmd_f,
  output logic [DATA_W-1:0]      unit_a,
  output logic [DATA_W-1:0]      unit_b,
  output logic [1:0]             unit_f,
  input  logic [DATA_W-1:0]      unit_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [DATA_W-1:0]      res_data,
  output logic [1:0]             res_f,
  output logic                   err,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned FW = 2 * DATA_W + 2;
  localparam int unsigned RW = DEF_DATA_W;

  state_t             state;
  state_t             next_state;
  logic               issue_c;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FW-1:0]      head;
  logic [DATA_W-1:0]  head_a;
  logic [DATA_W-1:0]  head_b;
  logic [1:0]         head_f;
  logic [1:0]         op;
  logic [DATA_W-1:0]  expected;

  assign cmd_ready = !fifo_full;
  assign {head_a, head_b, head_f} = head;

  logic_cmd_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (cmd_valid),
    .wr_data ({cmd_a, cmd_b, cmd_f}),
    .pop     (issue_c),
    .rd_data (head),
    .count   (count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Issue only when the result slot is free or being emptied this cycle.
  always_comb begin
    next_state = state;
    issue_c    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && (!res_valid || res_ready)) begin
          issue_c    = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE:   next_state = CAPT;
      CAPT:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Unit drive, golden expectation, result slot and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unit_a    <= '0;
      unit_b    <= '0;
      unit_f    <= '0;
      op        <= '0;
      expected  <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_f     <= '0;
      err       <= 1'b0;
    end else begin
      if (issue_c) begin
        unit_a   <= head_a;
        unit_b   <= head_b;
        unit_f   <= head_f;
        op       <= head_f;
        expected <= DATA_W'(logic_ref(RW'(head_a), RW'(head_b), head_f));
      end
      if (res_valid && res_ready) res_valid <= 1'b0;
      // The slot is always free here because IDLE only issued into a free slot.
      if (state == CAPT) begin
        res_valid <= 1'b1;
        res_data  <= unit_out;
        res_f     <= op;
        if (unit_out != expected) err <= 1'b1;
      end
    end
  end

endmodule
